par_shift_reg: RTL and testbench
================================

# par_shift_reg

Parametrised parallel/shift register. Successor to the fixed 8-bit parallel register: generic width, parallel load, four serial shift/rotate modes with an automatic WIDTH-bit transfer sequence, a busy/done handshake and an active-low output enable. Sits between the datapath bus (DATA/OUTRESULT) and serial links (SIN/SOUT) in the lab register subsystem.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CLOCK  input  1  system clock, rising edge
- RESET  input  1  synchronous, active-high reset
- DATA  input  WIDTH  parallel load data
- EWR  input  1  parallel write enable
- START  input  1  begin WIDTH-bit serial transfer
- MODE  input  2  00 shift right, 01 shift left, 10 rotate right, 11 rotate left
- SIN  input  1  serial input for shift modes
- EDY  input  1  output enable, active-low
- OUTRESULT  output  WIDTH  register contents when EDY=0
- SOUT  output  1  last bit shifted/rotated out (registered)
- BUSY  output  1  transfer in progress
- DONE  output  1  one-cycle pulse at transfer end

One clock; reset is synchronous and active-high.

## Operation
- States: IDLE, SHIFT. Internal reg R[WIDTH-1:0], bit counter CNT, latched mode M.
- RESET=1 at edge: R=0, CNT=0, state IDLE, BUSY=0, DONE=0, SOUT=0; overrides everything, including mid-transfer.
- IDLE: EWR=1 → R←DATA. START=1 with EWR=0 → M←MODE, CNT←0, state SHIFT. EWR and START together → load only, START dropped.
- SHIFT: one step per edge; CNT←CNT+1. EWR, START, MODE ignored.
  - 00: R←{SIN,R[W-1:1]}, SOUT←R[0]
  - 01: R←{R[W-2:0],SIN}, SOUT←R[W-1]
  - 10: R←{R[0],R[W-1:1]}, SOUT←R[0]
  - 11: R←{R[W-2:0],R[W-1]}, SOUT←R[W-1]
- On the WIDTH-th step: state IDLE, DONE=1 for one cycle. Rotate modes restore the original R.
- SOUT holds its value outside SHIFT.
- OUTRESULT combinational: EDY=0 → R, EDY=1 → all zeros. Never X. Intermediate values are visible during SHIFT.
- BUSY = (state==SHIFT).

## Timing
- Load: EWR sampled at edge k → OUTRESULT=DATA after edge k.
- START sampled at edge k → BUSY=1 after k. Steps at edges k+1…k+WIDTH.
- After edge k+WIDTH: BUSY=0, DONE=1. DONE falls after k+WIDTH+1.
- Total transfer: WIDTH+1 cycles from START to DONE. START during SHIFT is ignored.
- Earliest next START is accepted at edge k+WIDTH+1, concurrent with the DONE cycle.
- CNT width: $clog2(WIDTH+1). No wrap beyond WIDTH.

## Configuration
- PAR_SHIFT_REG_INV_OUT_EN defined: OUTRESULT = ~R when EDY=0, for legacy compatibility with the inverting parallel register. EDY=1 still gives all zeros. SOUT is not inverted.
- Not defined: OUTRESULT = R (true polarity).

## Structure
- Package par_reg_pkg:
  - mode enum (SHR, SHL, ROR, ROL)
  - state typedef (IDLE, SHIFT)
  - cnt_width function
- One sub-module, par_shift_ctrl: FSM, CNT, DONE/BUSY generation, mode latch. It outputs the step enable and latched mode.
- Datapath mux and R live in the top module.

## Test plan
(WIDTH=8)
- Reset: RESET=1 for one edge at step 4 of a transfer → OUTRESULT=0x00, BUSY=0, DONE=0, SOUT=0. No DONE pulse follows.
- Load and enable: DATA=0xA5, EWR=1, EDY=0 → OUTRESULT=0xA5 (0x5A with macro). EDY=1 → 0x00.
- Rotate right: load 0x81, MODE=10, START → BUSY for 8 cycles, DONE one cycle later, R=0x81. SOUT sequence is 1,0,0,0,0,0,0,1.
- Shift right fill: load 0x00, MODE=00, SIN=1, START → OUTRESULT 0x80, 0xC0, …, 0xFF. DONE after the 8th step.
- Collisions: EWR=1 with START=1 in IDLE → load only, BUSY stays 0. EWR=1 with DATA=0x3C during SHIFT → ignored.
- Mode latch: START with MODE=01 on 0x01, then MODE=00 mid-transfer → shifting continues left, ending at 0x00 with SIN=0. SOUT=1 on the 8th step.

Source files
------------

// File: rtl/par_reg_pkg.sv
// par_reg_pkg: shared types and helpers for the parallel/shift register.
`default_nettype none

package par_reg_pkg;

   typedef enum logic [1:0] {
      SHR = 2'b00,
      SHL = 2'b01,
      ROR = 2'b10,
      ROL = 2'b11
   } mode_e;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // Counter must hold the value WIDTH itself, hence WIDTH+1.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/par_shift_reg_if.sv
// par_shift_reg_if: datapath bus and serial link signals of par_shift_reg.
`default_nettype none

interface par_shift_reg_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] DATA;
   logic             EWR;
   logic             START;
   logic [1:0]       MODE;
   logic             SIN;
   logic             EDY;
   logic [WIDTH-1:0] OUTRESULT;
   logic             SOUT;
   logic             BUSY;
   logic             DONE;

   modport master (
      output DATA, EWR, START, MODE, SIN, EDY,
      input  OUTRESULT, SOUT, BUSY, DONE
   );

   modport slave (
      input  DATA, EWR, START, MODE, SIN, EDY,
      output OUTRESULT, SOUT, BUSY, DONE
   );
endinterface

`default_nettype wire

// File: rtl/par_shift_ctrl.sv
// par_shift_ctrl: transfer FSM, step counter, mode latch and BUSY/DONE generation.
`default_nettype none

module par_shift_ctrl
   import par_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ewr,
   input  logic       start,
   input  logic [1:0] mode,
   output logic       step_en,
   output mode_e      mode_l,
   output logic       busy,
   output logic       done
);

   localparam int CW = cnt_width(WIDTH);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   mode_e         mode_q, mode_d;
   logic          done_q, done_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= SHR;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
      step_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A simultaneous parallel write wins; the START is dropped.
            if (start && !ewr) begin
               mode_d  = mode_e'(mode);
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            step_en = 1'b1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
      endcase
   end

   assign mode_l = mode_q;
   assign busy   = (state_q == SHIFT);
   assign done   = done_q;

endmodule

`default_nettype wire

// File: rtl/par_shift_reg.sv
// par_shift_reg: parallel-load register with WIDTH-step serial shift/rotate transfers.
// Optional PAR_SHIFT_REG_INV_OUT_EN: OUTRESULT drives ~R while enabled.
`default_nettype none

module par_shift_reg
   import par_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic           CLOCK,
   input  logic           RESET,
   par_shift_reg_if.slave bus
);

   logic [WIDTH-1:0] r_q, r_d;
   logic             sout_q, sout_d;
   logic             step_en;
   mode_e            mode_l;
   logic             busy;
   logic             done;

   par_shift_ctrl #(
      .WIDTH (WIDTH)
   ) u_ctrl (
      .clk     (CLOCK),
      .rst     (RESET),
      .ewr     (bus.EWR),
      .start   (bus.START),
      .mode    (bus.MODE),
      .step_en (step_en),
      .mode_l  (mode_l),
      .busy    (busy),
      .done    (done)
   );

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_q    <= '0;
         sout_q <= 1'b0;
      end else begin
         r_q    <= r_d;
         sout_q <= sout_d;
      end
   end

   always_comb begin
      r_d    = r_q;
      sout_d = sout_q;
      if (step_en) begin
         unique case (mode_l)
            SHR: begin
               r_d    = {bus.SIN, r_q[WIDTH-1:1]};
               sout_d = r_q[0];
            end
            SHL: begin
               r_d    = {r_q[WIDTH-2:0], bus.SIN};
               sout_d = r_q[WIDTH-1];
            end
            ROR: begin
               r_d    = {r_q[0], r_q[WIDTH-1:1]};
               sout_d = r_q[0];
            end
            ROL: begin
               r_d    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
               sout_d = r_q[WIDTH-1];
            end
         endcase
      end else if (!busy && bus.EWR) begin
         r_d = bus.DATA;
      end
   end

`ifdef PAR_SHIFT_REG_INV_OUT_EN
   assign bus.OUTRESULT = bus.EDY ? '0 : ~r_q;
`else
   assign bus.OUTRESULT = bus.EDY ? '0 : r_q;
`endif
   assign bus.SOUT = sout_q;
   assign bus.BUSY = busy;
   assign bus.DONE = done;

endmodule

`default_nettype wire

// File: tb/tb_par_shift_reg.sv
// tb_par_shift_reg: directed and random stimulus against an arithmetic reference model.
`default_nettype none

module tb_par_shift_reg;

   localparam int W    = 8;
   localparam int MASK = (1 << W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   par_shift_reg_if #(.WIDTH(W)) bus ();

   par_shift_reg #(.WIDTH(W)) dut (
      .CLOCK (clk),
      .RESET (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state.
   int m_r     = 0;
   int m_sout  = 0;
   int m_busy  = 0;
   int m_done  = 0;
   int m_left  = 0;
   int m_mode  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, got, exp);
   endtask

   function automatic int exp_out();
      if (bus.EDY) return 0;
`ifdef PAR_SHIFT_REG_INV_OUT_EN
      return (~m_r) & MASK;
`else
      return m_r;
`endif
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".out"},  32'(bus.OUTRESULT), 32'(exp_out()));
      chk({tag, ".sout"}, 32'(bus.SOUT),      32'(m_sout));
      chk({tag, ".busy"}, 32'(bus.BUSY),      32'(m_busy));
      chk({tag, ".done"}, 32'(bus.DONE),      32'(m_done));
   endtask

   // Advance the model with the inputs presented before the edge, then clock the DUT.
   task automatic tick(input string tag);
      int s;
      s = int'(bus.SIN);
      if (rst) begin
         m_r = 0; m_sout = 0; m_busy = 0; m_done = 0; m_left = 0;
      end else begin
         m_done = 0;
         if (m_busy != 0) begin
            case (m_mode)
               0: begin m_sout = m_r % 2;          m_r = (m_r / 2) + s * (1 << (W-1)); end
               1: begin m_sout = m_r / (1<<(W-1)); m_r = ((m_r * 2) & MASK) + s; end
               2: begin m_sout = m_r % 2;          m_r = (m_r / 2) + (m_r % 2) * (1 << (W-1)); end
               default: begin m_sout = m_r / (1<<(W-1)); m_r = ((m_r * 2) & MASK) + m_sout; end
            endcase
            m_left--;
            if (m_left == 0) begin m_busy = 0; m_done = 1; end
         end else if (bus.EWR) begin
            m_r = int'(bus.DATA);
         end else if (bus.START) begin
            m_busy = 1; m_left = W; m_mode = int'(bus.MODE);
         end
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic idle_inputs();
      bus.DATA = '0; bus.EWR = 1'b0; bus.START = 1'b0;
      bus.MODE = 2'b00; bus.SIN = 1'b0; bus.EDY = 1'b0;
   endtask

   initial begin
      logic [7:0] sout_seq;
      idle_inputs();
      rst = 1'b1;
      tick("reset");
      tick("reset2");
      rst = 1'b0;

      // Parallel load and output enable.
      bus.DATA = 8'hA5; bus.EWR = 1'b1;
      tick("load_a5");
      bus.EWR = 1'b0;
`ifdef PAR_SHIFT_REG_INV_OUT_EN
      chk("load_a5.const", 32'(bus.OUTRESULT), 32'h5A);
`else
      chk("load_a5.const", 32'(bus.OUTRESULT), 32'hA5);
`endif
      bus.EDY = 1'b1; #1;
      chk("edy_hi.out", 32'(bus.OUTRESULT), 32'h00);
      bus.EDY = 1'b0;

      // Rotate right of 0x81: record the SOUT sequence and end value.
      bus.DATA = 8'h81; bus.EWR = 1'b1;
      tick("load_81");
      bus.EWR = 1'b0; bus.MODE = 2'b10; bus.START = 1'b1;
      tick("ror_start");
      bus.START = 1'b0;
      for (int i = 0; i < W; i++) begin
         tick("ror_step");
         sout_seq[7-i] = bus.SOUT;
      end
      chk("ror.sout_seq", 32'(sout_seq), 32'h81);
      chk("ror.done", 32'(bus.DONE), 32'h1);
      chk("ror.restore", 32'(dut.r_q), 32'h81);
      tick("ror_after");

      // Shift right fill with SIN=1 from 0x00.
      bus.DATA = 8'h00; bus.EWR = 1'b1;
      tick("load_00");
      bus.EWR = 1'b0; bus.MODE = 2'b00; bus.SIN = 1'b1; bus.START = 1'b1;
      tick("shr_start");
      bus.START = 1'b0;
      for (int i = 0; i < W; i++) tick("shr_fill");
      chk("shr_fill.end", 32'(dut.r_q), 32'hFF);
      bus.SIN = 1'b0;

      // EWR with START in IDLE loads only.
      bus.DATA = 8'h5C; bus.EWR = 1'b1; bus.START = 1'b1;
      tick("collide_idle");
      chk("collide_idle.busy", 32'(bus.BUSY), 32'h0);
      bus.EWR = 1'b0; bus.START = 1'b0;
      tick("collide_idle2");

      // Mode latch: left shift continues despite MODE change; EWR during SHIFT ignored.
      bus.DATA = 8'h01; bus.EWR = 1'b1;
      tick("load_01");
      bus.EWR = 1'b0; bus.MODE = 2'b01; bus.START = 1'b1;
      tick("shl_start");
      bus.START = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (i == 3) begin bus.MODE = 2'b00; bus.DATA = 8'h3C; bus.EWR = 1'b1; end
         tick("shl_step");
      end
      bus.EWR = 1'b0;
      chk("shl.end", 32'(dut.r_q), 32'h00);
      chk("shl.sout8", 32'(bus.SOUT), 32'h1);

      // Back-to-back START accepted in the DONE cycle.
      bus.DATA = 8'h96; bus.EWR = 1'b1;
      tick("load_96");
      bus.EWR = 1'b0; bus.MODE = 2'b11; bus.START = 1'b1;
      tick("rol_start");
      for (int i = 0; i < 2 * W + 1; i++) tick("rol_b2b");
      bus.START = 1'b0;
      for (int i = 0; i < W + 2; i++) tick("rol_drain");

      // Reset at step 4 of a transfer, then confirm no DONE follows.
      bus.MODE = 2'b10; bus.START = 1'b1;
      tick("rst_start");
      bus.START = 1'b0;
      for (int i = 0; i < 4; i++) tick("rst_step");
      rst = 1'b1;
      tick("rst_mid");
      chk("rst_mid.out", 32'(bus.OUTRESULT), 32'h0);
      rst = 1'b0;
      for (int i = 0; i < W + 2; i++) tick("rst_quiet");

      // Random traffic.
      for (int i = 0; i < 2000; i++) begin
         rst       = ($urandom_range(0, 99) == 0);
         bus.DATA  = W'($urandom);
         bus.EWR   = ($urandom_range(0, 5) == 0);
         bus.START = ($urandom_range(0, 3) == 0);
         bus.MODE  = 2'($urandom);
         bus.SIN   = 1'($urandom);
         bus.EDY   = ($urandom_range(0, 7) == 0);
         tick("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
